// File: rtl/imem_loader.sv
// Instruction memory with a UART boot loader that holds the core in reset while loading.
// Define LOADER_CHECKSUM_EN to require and verify a trailing checksum byte per frame.
module imem_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [15:0] imem_addr_in,
  output logic [31:0] imem_rd_data_out,
  output logic        cpu_rst_out,
  output logic        load_busy,
  output logic        load_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0]   CAP   = 17'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e S_FIN = S_CSUM;
`else
  localparam state_e S_FIN = S_DONE;
`endif

  state_e            state_q;
  logic [15:0]       len_q;
  logic [15:0]       len_d;
  logic [15:0]       wcnt_q;
  logic [1:0]        lane_q;
  logic [23:0]       asm_q;
  logic [TW-1:0]     tcnt_q;
  logic              busy_q;
  logic              crst_q;
  logic              err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_q;
  logic              we;
  logic [31:0]       wdata;
  logic [ADDR_WIDTH-1:0] widx;
  logic [ADDR_WIDTH-1:0] ridx;
  logic              in_frame;
  logic              timeout;
  logic              unused_addr;

  assign len_d    = {rx_data, len_q[7:0]};
  assign in_frame = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign timeout  = in_frame && !rx_valid && (tcnt_q == TLAST);
  assign we       = (state_q == S_DATA) && rx_valid && (lane_q == 2'd3);
  assign wdata    = {rx_data, asm_q};
  assign widx     = wcnt_q[ADDR_WIDTH-1:0];
  assign ridx     = imem_addr_in[ADDR_WIDTH+1:2];
  // Only the word-index bits select data; the rest are deliberately ignored.
  assign unused_addr = ^imem_addr_in;

  // Frame parser: header, length, payload, optional checksum, then a one-cycle outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      tcnt_q  <= '0;
      busy_q  <= 1'b0;
      crst_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      if (in_frame) begin
        tcnt_q <= rx_valid ? '0 : tcnt_q + TW'(1);
      end
      unique case (state_q)
        S_IDLE: begin
          if (rx_valid && rx_data == 8'hA5) begin
            state_q <= S_LEN0;
            busy_q  <= 1'b1;
            crst_q  <= 1'b1;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
          end
        end
        S_LEN0: begin
          if (timeout) begin
            state_q <= S_ERROR;
          end else if (rx_valid) begin
            len_q[7:0] <= rx_data;
            state_q    <= S_LEN1;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= rx_data;
`endif
          end
        end
        S_LEN1: begin
          if (timeout) begin
            state_q <= S_ERROR;
          end else if (rx_valid) begin
            len_q  <= len_d;
            wcnt_q <= '0;
            lane_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q  <= sum_q + rx_data;
`endif
            if ({1'b0, len_d} > CAP) begin
              state_q <= S_ERROR;
            end else if (len_d == 16'd0) begin
              state_q <= S_FIN;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (timeout) begin
            state_q <= S_ERROR;
          end else if (rx_valid) begin
            lane_q <= lane_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q  <= sum_q + rx_data;
`endif
            unique case (lane_q)
              2'd0: asm_q[7:0]   <= rx_data;
              2'd1: asm_q[15:8]  <= rx_data;
              2'd2: asm_q[23:16] <= rx_data;
              default: begin
                wcnt_q <= wcnt_q + 16'd1;
                if (wcnt_q == len_q - 16'd1) begin
                  state_q <= S_FIN;
                end
              end
            endcase
          end
        end
        S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
          if (timeout) begin
            state_q <= S_ERROR;
          end else if (rx_valid) begin
            state_q <= (rx_data == sum_q) ? S_DONE : S_ERROR;
          end
`else
          state_q <= S_ERROR;
`endif
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          crst_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERROR: begin
          busy_q  <= 1'b0;
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Array write port: the word lands on the edge that accepts its last byte.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Registered fetch port; a same-index write in this cycle yields the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[ridx];
    end
  end

  assign imem_rd_data_out = rd_q;
  assign cpu_rst_out      = crst_q;
  assign load_busy        = busy_q;
  assign load_err         = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a byte-position reference model.
// Works with LOADER_CHECKSUM_EN defined or undefined.
module tb_imem_loader;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 40;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] imem_addr_in = 16'h0000;
  logic [31:0] imem_rd_data_out;
  logic        cpu_rst_out;
  logic        load_busy;
  logic        load_err;

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .imem_addr_in     (imem_addr_in),
    .imem_rd_data_out (imem_rd_data_out),
    .cpu_rst_out      (cpu_rst_out),
    .load_busy        (load_busy),
    .load_err         (load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];
  logic [31:0] m_rd = 32'h0;
  bit          m_rdk = 1'b1;
  bit          m_inf = 1'b0;
  int          m_pend = 0;
  int          m_pos = 0;
  int          m_n = 0;
  int          m_idle = 0;
  logic [7:0]  m_sum = 8'h00;
  logic [31:0] m_word = 32'h0;
  bit          m_busy = 1'b0;
  bit          m_crst = 1'b0;
  bit          m_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic end_frame(input int k);
    m_inf  = 1'b0;
    m_pend = k;
  endtask

  task automatic model_step();
    int idx;
    int p;
    idx = int'(imem_addr_in[AW+1:2]);
    m_rd  = m_mem[idx];
    m_rdk = m_vld[idx];
    if (m_pend != 0) begin
      m_busy = 1'b0;
      if (m_pend == 1) m_crst = 1'b0;
      else m_err = 1'b1;
      m_pend = 0;
    end else if (!m_inf) begin
      if (rx_valid && rx_data == 8'hA5) begin
        m_inf = 1'b1; m_pos = 0; m_idle = 0; m_n = 0; m_sum = 8'h00;
        m_busy = 1'b1; m_crst = 1'b1; m_err = 1'b0;
      end
    end else if (!rx_valid) begin
      m_idle++;
      if (m_idle == TMO) end_frame(2);
    end else begin
      m_idle = 0;
      m_pos++;
      if (m_pos <= 2) begin
        m_n = m_n + (int'(rx_data) << (8 * (m_pos - 1)));
        m_sum = m_sum + rx_data;
        if (m_pos == 2) begin
          if (m_n > DEPTH) end_frame(2);
          else if (m_n == 0 && !CS) end_frame(1);
        end
      end else if (m_pos <= 2 + 4 * m_n) begin
        p = m_pos - 3;
        m_sum = m_sum + rx_data;
        m_word[8*(p%4) +: 8] = rx_data;
        if (p % 4 == 3) begin
          m_mem[p/4] = m_word;
          m_vld[p/4] = 1'b1;
          if (p / 4 == m_n - 1 && !CS) end_frame(1);
        end
      end else begin
        end_frame(rx_data == m_sum ? 1 : 2);
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) model_step();
  end

  // compare outputs against the model every cycle
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("cpu_rst_out", 32'(cpu_rst_out), 32'(m_crst));
      chk("load_busy", 32'(load_busy), 32'(m_busy));
      chk("load_err", 32'(load_err), 32'(m_err));
      if (m_rdk) chk("rd_data", imem_rd_data_out, m_rd);
    end
  end

  task automatic cyc_a(input bit v, input logic [7:0] d, input logic [15:0] a);
    @(negedge clk);
    rx_valid = v;
    rx_data = d;
    imem_addr_in = a;
  endtask

  task automatic cyc(input bit v, input logic [7:0] d);
    logic [15:0] a;
    a = {2'($urandom), 12'($urandom_range(0, 15)), 2'($urandom)};
    cyc_a(v, d, a);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic send_q(input logic [7:0] q[$], input int maxgap);
    foreach (q[i]) begin
      idle($urandom_range(0, maxgap));
      cyc(1'b1, q[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    m_inf = 1'b0; m_pend = 0; m_busy = 1'b0; m_crst = 1'b0; m_err = 1'b0;
    m_rd = 32'h0; m_rdk = 1'b1;
    #1;
    chk("rst_cpu_rst", 32'(cpu_rst_out), 32'h0);
    chk("rst_busy", 32'(load_busy), 32'h0);
    chk("rst_err", 32'(load_err), 32'h0);
    chk("rst_rd", imem_rd_data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic read_lit(input string nm, input logic [15:0] a,
                          input logic [31:0] exp);
    cyc_a(1'b0, 8'h00, a);
    @(posedge clk);
    #2 chk(nm, imem_rd_data_out, exp);
  endtask

  function automatic void plan_frame(output logic [7:0] q[$]);
    q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00};
    if (CS) q.push_back(8'hB8);
  endfunction

  task automatic rand_frame();
    logic [7:0] q[$];
    logic [7:0] s;
    int kind;
    int n;
    int cut;
    kind = $urandom_range(0, 9);
    n = $urandom_range(0, 6);
    if ($urandom_range(0, 3) == 0) begin
      for (int i = 0; i < 3; i++) q.push_back(8'($urandom_range(0, 8'hA4)));
    end
    q.push_back(8'hA5);
    if (kind == 0) n = 4097 + $urandom_range(0, 60000);
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    s = 8'(n) + 8'(n >> 8);
    if (kind != 0) begin
      for (int i = 0; i < 4 * n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        q.push_back(b);
        s = s + b;
      end
      if (CS) q.push_back(kind == 2 ? s + 8'd1 : s);
    end
    if (kind == 1) begin
      cut = $urandom_range(1, q.size() - 1);
      while (q.size() > cut) void'(q.pop_back());
    end
    send_q(q, 2);
    if (kind == 1) idle(TMO + 2);
    else idle($urandom_range(0, 2));
  endtask

  initial begin
    logic [7:0] q[$];
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;

    #3;
    chk("init_cpu_rst", 32'(cpu_rst_out), 32'h0);
    chk("init_busy", 32'(load_busy), 32'h0);
    chk("init_err", 32'(load_err), 32'h0);
    chk("init_rd", imem_rd_data_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    q = '{8'h00, 8'hFF, 8'h5A};
    send_q(q, 1);
    idle(2);
    #1;
    chk("junk_cpu_rst", 32'(cpu_rst_out), 32'h0);
    chk("junk_busy", 32'(load_busy), 32'h0);
    chk("junk_err", 32'(load_err), 32'h0);

    plan_frame(q);
    send_q(q, 1);
    @(posedge clk);
    #2 chk("plan_rst_in_done", 32'(cpu_rst_out), 32'h1);
    cyc(1'b0, 8'h00);
    @(posedge clk);
    #2 chk("plan_rst_released", 32'(cpu_rst_out), 32'h0);
    chk("plan_err", 32'(load_err), 32'h0);
    read_lit("plan_word0", 16'h0000, 32'h00000013);
    read_lit("plan_word1", 16'hC007, 32'h00100093);

`ifdef LOADER_CHECKSUM_EN
    q[11] = 8'hB9;
    send_q(q, 1);
    idle(3);
    #1;
    chk("badcs_err", 32'(load_err), 32'h1);
    chk("badcs_cpu_rst", 32'(cpu_rst_out), 32'h1);
    read_lit("badcs_word1", 16'h0004, 32'h00100093);
`endif

    q = '{8'hA5, 8'h01, 8'h10};
    send_q(q, 0);
    idle(3);
    #1;
    chk("big_err", 32'(load_err), 32'h1);
    chk("big_cpu_rst", 32'(cpu_rst_out), 32'h1);
    read_lit("big_nowrite", 16'h0000, 32'h00000013);

    q = '{8'hA5, 8'h01, 8'h00, 8'h13};
    send_q(q, 0);
    idle(TMO + 3);
    #1;
    chk("tmo_err", 32'(load_err), 32'h1);
    chk("tmo_busy", 32'(load_busy), 32'h0);
    plan_frame(q);
    send_q(q, 2);
    idle(3);
    #1;
    chk("recover_err", 32'(load_err), 32'h0);
    chk("recover_cpu_rst", 32'(cpu_rst_out), 32'h0);

    q = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
    send_q(q, 1);
    do_reset();
    q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    if (CS) q.push_back(8'h01 + 8'hEF + 8'hBE + 8'hAD + 8'hDE);
    send_q(q, 1);
    idle(3);
    read_lit("after_rst_word", 16'h0000, 32'hDEADBEEF);

    for (int i = 0; i < 60; i++) rand_frame();
    idle(TMO + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction memory with a UART byte-stream boot loader, placed directly upstream of the CPU core's fetch port. It serves registered 32-bit instruction reads at the core's 16-bit byte address. It also accepts a framed program image from the UART receive path and writes it into the instruction array. While an image is being written, it holds the core in reset.

## Interface
Parameters:
- ADDR_WIDTH, 12: word-address width; capacity is 2^ADDR_WIDTH 32-bit words.
- TIMEOUT_CYCLES, 1_000_000: maximum idle cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous and active-high.
- rx_valid  in  1  one-cycle pulse; rx_data carries a received byte.
- rx_data  in  8  received UART byte.
- imem_addr_in  in  16  fetch byte address from the core; bits [ADDR_WIDTH+1:2] index the array.
- imem_rd_data_out  out  32  fetched instruction word to the core.
- cpu_rst_out  out  1  active-high reset request to the core.
- load_busy  out  1  high while a frame is in progress.
- load_err  out  1  sticky frame-error flag.

## Operation
Frame format, all fields little-endian:
- Header 0xA5.
- Length field: 2 bytes, N = word count.
- Payload: N×4 bytes. Each word is sent LSB first and written at word index 0..N-1.
- Checksum: 1 byte, present only when the checksum feature is compiled in.

State machine:
- IDLE: bytes other than 0xA5 are ignored. 0xA5 moves to LEN0, sets load_busy and cpu_rst_out, and clears load_err.
- LEN0 → LEN1: the two length bytes are captured.
- After LEN1:
  - N > 2^ADDR_WIDTH: ERROR.
  - N == 0: CSUM, or DONE when the checksum feature is compiled out.
  - Otherwise: DATA.
- DATA: a byte lane counter (0..3) assembles the word. On the 4th byte, the word is written to mem[word_ptr] and word_ptr is incremented. After word N-1: CSUM, or DONE when the checksum feature is compiled out.
- CSUM: the received byte is compared with the running 8-bit sum (mod 256) of both length bytes and all payload bytes. Match: DONE. Mismatch: ERROR.
- DONE, one cycle: load_busy clears and cpu_rst_out clears. Then IDLE.
- ERROR, one cycle: load_busy clears, load_err is set, and cpu_rst_out stays high. Then IDLE.
- Timeout: in LEN0, LEN1, DATA or CSUM, a counter counts cycles without rx_valid and is reset by each byte. Reaching TIMEOUT_CYCLES goes to ERROR.

Error-state behaviour:
- cpu_rst_out stays high after an error until a later frame reaches DONE, or until rst.
- Words already written by an aborted frame remain in the array.

Read port:
- imem_rd_data_out <= mem[imem_addr_in[ADDR_WIDTH+1:2]] every cycle, regardless of state.
- Address bits above ADDR_WIDTH+1 are ignored.
- Address bits [1:0] are ignored.

## Timing
- Reset values: imem_rd_data_out = 0, cpu_rst_out = 0, load_busy = 0, load_err = 0, state IDLE. The array contents are not reset.
- Read latency is 1 cycle: the address applied in cycle t gives its data after edge t+1.
- Header accepted at edge t: cpu_rst_out and load_busy are high after edge t.
- A word write occurs on the edge that accepts its 4th byte.
- Read-during-write to the same index returns the old data.
- Final byte accepted at edge t: the state is DONE after t, and cpu_rst_out/load_busy are low after edge t+1.
- rx_valid while in DONE or ERROR: the byte is dropped.
- Reset asserted mid-frame: an immediate asynchronous return to IDLE with all outputs at their reset values. Partial data remains in the array.
- No back-pressure: every rx_valid pulse is consumed in the cycle it is present.

## Configuration
- LOADER_CHECKSUM_EN defined: the frame carries the trailing checksum byte, which is verified as described above. A mismatch gives ERROR.
- LOADER_CHECKSUM_EN undefined: there is no checksum byte, no sum is accumulated, and the frame completes after the last payload byte (or after LEN1 when N = 0).

## Test plan
- Checksum on, stream A5 02 00 13 00 00 00 93 00 10 00 B8:
  - load_err = 0; cpu_rst_out is high from the header and falls one cycle after DONE.
  - Read 0x0000 returns 0x00000013; read 0x0004 returns 0x00100093.
- Same stream with checksum byte B9: load_err = 1, cpu_rst_out stays 1, and both words are still readable.
- Stream A5 01 10 (N = 4097 with ADDR_WIDTH = 12): ERROR immediately after the second length byte, and no array writes occur.
- Stream A5 01 00 13: then no bytes for TIMEOUT_CYCLES, so load_err = 1 and the state is IDLE. A following valid frame clears load_err and releases cpu_rst_out.
- Bytes 00 FF 5A in IDLE: ignored, and cpu_rst_out, load_busy and load_err all remain 0.
- Assert rst after the 6th byte of a frame: outputs return to reset values asynchronously. A subsequent complete frame loads correctly.
